lenet_weight_layer_scheduler: RTL and testbench
===============================================

Name: lenet_weight_layer_scheduler

Overview:
- Sequences the LeNet weight-readout SRAM readers (absolute-value reader and sign reader) through layer 1 -> 2 -> 3 for one inference.
- Drives the shared one-hot `layer` bus and a single-cycle `integration_start` to both readers.
- Monitors their valid streams for end-of-layer, beat count and abs/sign lockstep.
- Sits between the inference control FSM (start/done handshake) and the weight readers; gates each layer on the activation buffer being ready.

Parameters:
- LAYER_1_BEATS, 14700, expected valid beats per reader for layer 1
- LAYER_2_BEATS, 1900, expected valid beats for layer 2
- LAYER_3_BEATS, 70, expected valid beats for layer 3
- START_LATENCY_MAX, 8, max cycles from `integration_start` to first valid beat
- GAP_CYCLES, 4, idle cycles between layers with `layer`=3'b000
- TIMEOUT_CYCLES, 65535, per-layer watchdog limit (only used with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inf_start  in  1  pulse: begin an inference; ignored unless `idle`=1
- act_ready  in  1  activation buffer ready for the current layer (level)
- abs_valid  in  1  valid from the absolute-value reader
- sign_valid  in  1  valid from the sign reader
- layer  out  3  one-hot layer select to both readers
- integration_start  out  1  single-cycle start pulse to both readers
- idle  out  1  high in IDLE
- layer_done  out  1  pulse at the end of each layer
- inf_done  out  1  pulse after layer 3 completes
- beat_err  out  1  sticky: beat count ≠ expected
- sync_err  out  1  sticky: `abs_valid` ≠ `sign_valid` in some cycle
- start_err  out  1  sticky: no valid within START_LATENCY_MAX
- timeout_err  out  1  sticky watchdog error (optional feature only; else tied 0)

Behaviour:
- Reset is asynchronous on `rst_n` low and is the only path to reset state. Reset values:
  - state = IDLE, `layer` = 0, all pulses 0, all sticky errors 0, `idle` = 1.
  - Internal beat counter is 0; its width is clog2(LAYER_1_BEATS+1).
- Reset asserted mid-layer aborts immediately: `layer` = 0 forces the readers to drop valid. No done pulse is emitted.
- States:
  - IDLE: `inf_start` -> ARM with cur = 3'b001.
  - ARM: drive `layer` = cur. When `act_ready` = 1 -> START.
  - START: `integration_start` = 1 for exactly one cycle, `layer` = cur. Clear the beat counter and start-latency counter -> WAIT.
  - WAIT: hold `layer`. When the first cycle has `abs_valid` | `sign_valid` = 1 -> STREAM, and count that beat. If the latency counter reaches START_LATENCY_MAX with no valid: set `start_err`, pulse `layer_done`, -> GAP.
  - STREAM: hold `layer`.
    - Each cycle with `abs_valid` = 1 increments the beat counter; the counter saturates at all-ones.
    - The first cycle with both valids = 0 ends the layer. Compare the count with LAYER_n_BEATS; on mismatch set `beat_err`. Pulse `layer_done` that cycle -> GAP.
  - GAP: `layer` = 0 for GAP_CYCLES cycles. Then:
    - if cur = 3'b100: pulse `inf_done` -> IDLE;
    - else cur <<= 1 -> ARM.
- `sync_err` is set in any cycle of WAIT or STREAM where `abs_valid` ≠ `sign_valid`.
- `act_ready` falling during WAIT or STREAM is ignored; it is sampled only in ARM.
- `inf_start` while not IDLE is ignored, and no error is flagged.
- Sticky errors clear only on reset or on an accepted `inf_start`.
- `layer` changes only on entering ARM or GAP, and is never non-one-hot except 0.
- `integration_start` never coincides with `layer` = 0.
- Outputs are registered; `layer_done` and `inf_done` are single-cycle.

Optional Feature:
- LAYER_WATCHDOG_EN
  - Defined: a cycle counter runs from START through STREAM. If it reaches TIMEOUT_CYCLES:
    - set `timeout_err`;
    - force `layer` = 0;
    - pulse `layer_done`;
    - go to IDLE without `inf_done`.
  - Undefined: no counter is present, `timeout_err` = 0, and STREAM waits indefinitely.

Test Plan:
- LAYER_n_BEATS = 4/3/2, reader model with valid 3 cycles after start. Pulse `inf_start` with `act_ready` = 1 -> expected response:
  - `layer` sequence 001, 000, 010, 000, 100, 000;
  - three `integration_start` pulses;
  - three `layer_done` pulses, one `inf_done`;
  - all errors 0.
- `act_ready` held 0 for 20 cycles in ARM of layer 2 -> `layer` = 010, no `integration_start` until `act_ready` rises, then a start pulse the next cycle.
- Reader gives 5 beats on layer 1 (expected 4) -> `beat_err` = 1 at layer-1 `layer_done`; the sequence still completes with `inf_done`.
- `sign_valid` drops one cycle early vs `abs_valid` -> `sync_err` = 1, sticky through `inf_done`, cleared by the next `inf_start`.
- Reader never asserts valid, START_LATENCY_MAX = 8 -> `start_err` 9 cycles after `integration_start`, then GAP and advance to layer 2.
- `rst_n` low mid-STREAM of layer 2 -> immediately `layer` = 0, `idle` = 1, no `inf_done`. With LAYER_WATCHDOG_EN and TIMEOUT_CYCLES = 10, a stuck-high valid -> `timeout_err` at cycle 10, then IDLE.

Source files
------------

// File: rtl/lenet_weight_layer_scheduler.sv
// Steps the LeNet abs/sign weight readers through layers 1->2->3, checking beat count, lockstep and start latency.
// Latency: every output is registered, so it reflects the state one cycle after the inputs that caused it.
// Backpressure: a layer starts only when act_ready is high in ARM. LAYER_WATCHDOG_EN adds a per-layer cycle watchdog.
module lenet_weight_layer_scheduler #(
    parameter int LAYER_1_BEATS     = 14700,
    parameter int LAYER_2_BEATS     = 1900,
    parameter int LAYER_3_BEATS     = 70,
    parameter int START_LATENCY_MAX = 8,
    parameter int GAP_CYCLES        = 4,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inf_start,
    input  logic       act_ready,
    input  logic       abs_valid,
    input  logic       sign_valid,
    output logic [2:0] layer,
    output logic       integration_start,
    output logic       idle,
    output logic       layer_done,
    output logic       inf_done,
    output logic       beat_err,
    output logic       sync_err,
    output logic       start_err,
    output logic       timeout_err
);

    localparam int BW = $clog2(LAYER_1_BEATS + 1);
    localparam int LW = $clog2(START_LATENCY_MAX + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [BW-1:0] EXP1     = BW'(LAYER_1_BEATS);
    localparam logic [BW-1:0] EXP2     = BW'(LAYER_2_BEATS);
    localparam logic [BW-1:0] EXP3     = BW'(LAYER_3_BEATS);
    localparam logic [LW-1:0] LAT_LAST = LW'(START_LATENCY_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cur_q, cur_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    layer_q, layer_d;
    logic          istart_q, istart_d;
    logic          idle_q, idle_d;
    logic          ldone_q, ldone_d;
    logic          idone_q, idone_d;
    logic          beat_err_q, beat_err_d;
    logic          sync_err_q, sync_err_d;
    logic          start_err_q, start_err_d;

`ifdef LAYER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          tmo_q, tmo_d;
`endif

    logic [BW-1:0] exp_beats;
    logic [BW-1:0] beat_inc;
    logic          any_vld;

    always_comb begin
        exp_beats = EXP3;
        if (cur_q[0]) begin
            exp_beats = EXP1;
        end else if (cur_q[1]) begin
            exp_beats = EXP2;
        end
    end

    // Saturate so a runaway reader cannot wrap back onto the expected count.
    assign beat_inc = (&beat_q) ? beat_q : beat_q + BW'(1);
    assign any_vld  = abs_valid | sign_valid;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        beat_d      = beat_q;
        lat_d       = lat_q;
        gap_d       = gap_q;
        layer_d     = layer_q;
        istart_d    = 1'b0;
        ldone_d     = 1'b0;
        idone_d     = 1'b0;
        beat_err_d  = beat_err_q;
        sync_err_d  = sync_err_q;
        start_err_d = start_err_q;
`ifdef LAYER_WATCHDOG_EN
        wd_d        = wd_q;
        tmo_d       = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (inf_start) begin
                    state_d     = S_ARM;
                    cur_d       = 3'b001;
                    layer_d     = 3'b001;
                    beat_err_d  = 1'b0;
                    sync_err_d  = 1'b0;
                    start_err_d = 1'b0;
`ifdef LAYER_WATCHDOG_EN
                    tmo_d       = 1'b0;
`endif
                end
            end
            S_ARM: begin
                if (act_ready) begin
                    state_d  = S_START;
                    istart_d = 1'b1;
                    beat_d   = '0;
                    lat_d    = '0;
`ifdef LAYER_WATCHDOG_EN
                    wd_d     = '0;
`endif
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (any_vld) begin
                    state_d = S_STREAM;
                    if (abs_valid) begin
                        beat_d = beat_inc;
                    end
                end else if (lat_q == LAT_LAST) begin
                    start_err_d = 1'b1;
                    ldone_d     = 1'b1;
                    layer_d     = 3'b000;
                    gap_d       = '0;
                    state_d     = S_GAP;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_STREAM: begin
                if (!any_vld) begin
                    if (beat_q != exp_beats) begin
                        beat_err_d = 1'b1;
                    end
                    ldone_d = 1'b1;
                    layer_d = 3'b000;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (abs_valid) begin
                    beat_d = beat_inc;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (cur_q == 3'b100) begin
                        idone_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cur_d   = {cur_q[1:0], 1'b0};
                        layer_d = {cur_q[1:0], 1'b0};
                        state_d = S_ARM;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                layer_d = 3'b000;
            end
        endcase

        if ((state_q == S_WAIT || state_q == S_STREAM) && (abs_valid != sign_valid)) begin
            sync_err_d = 1'b1;
        end

`ifdef LAYER_WATCHDOG_EN
        // The watchdog wins over any layer-end decision made in the same cycle.
        if (state_q == S_START || state_q == S_WAIT || state_q == S_STREAM) begin
            if (wd_q == WD_LAST) begin
                tmo_d   = 1'b1;
                ldone_d = 1'b1;
                idone_d = 1'b0;
                layer_d = 3'b000;
                state_d = S_IDLE;
            end else begin
                wd_d = wd_q + WW'(1);
            end
        end
`endif

        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= 3'b001;
            beat_q      <= '0;
            lat_q       <= '0;
            gap_q       <= '0;
            layer_q     <= 3'b000;
            istart_q    <= 1'b0;
            idle_q      <= 1'b1;
            ldone_q     <= 1'b0;
            idone_q     <= 1'b0;
            beat_err_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            start_err_q <= 1'b0;
`ifdef LAYER_WATCHDOG_EN
            wd_q        <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            gap_q       <= gap_d;
            layer_q     <= layer_d;
            istart_q    <= istart_d;
            idle_q      <= idle_d;
            ldone_q     <= ldone_d;
            idone_q     <= idone_d;
            beat_err_q  <= beat_err_d;
            sync_err_q  <= sync_err_d;
            start_err_q <= start_err_d;
`ifdef LAYER_WATCHDOG_EN
            wd_q        <= wd_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign layer             = layer_q;
    assign integration_start = istart_q;
    assign idle              = idle_q;
    assign layer_done        = ldone_q;
    assign inf_done          = idone_q;
    assign beat_err          = beat_err_q;
    assign sync_err          = sync_err_q;
    assign start_err         = start_err_q;
`ifdef LAYER_WATCHDOG_EN
    assign timeout_err       = tmo_q;
`else
    assign timeout_err       = 1'b0;
`endif

endmodule

// File: tb/tb_lenet_weight_layer_scheduler.sv
// Bench for lenet_weight_layer_scheduler: table of per-inference reader behaviours plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_lenet_weight_layer_scheduler;

    logic       clk = 1'b0;
    logic       rst_n, inf_start, act_ready, abs_valid, sign_valid;
    logic [2:0] layer;
    logic       integration_start, idle, layer_done, inf_done;
    logic       beat_err, sync_err, start_err, timeout_err;

    always #5 clk = ~clk;

    lenet_weight_layer_scheduler #(
        .LAYER_1_BEATS(4), .LAYER_2_BEATS(3), .LAYER_3_BEATS(2),
        .START_LATENCY_MAX(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inf_start(inf_start), .act_ready(act_ready),
        .abs_valid(abs_valid), .sign_valid(sign_valid), .layer(layer),
        .integration_start(integration_start), .idle(idle), .layer_done(layer_done),
        .inf_done(inf_done), .beat_err(beat_err), .sync_err(sync_err),
        .start_err(start_err), .timeout_err(timeout_err)
    );

    typedef struct {
        int   a1, a2, a3, s1, s2, s3;
        logic eb, es, est;
    } vec_t;
    typedef struct {
        logic b, s, st;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rd_abs[3];
    int         rd_sign[3];
    exp_t       sb[$];
    logic [2:0] seq[$];
    logic [2:0] exp_seq[6] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    int         exp_n[3] = '{4, 3, 2};
    int         n_istart, n_ldone, n_idone, viol, start_lat, istart_cyc, zrun, last_gap;
    vec_t       vecs[8];

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reader model: valid starts 3 cycles after integration_start, abs and sign lengths independent.
    initial begin
        int   rd_t;
        int   idx;
        logic on;
        abs_valid = 1'b0; sign_valid = 1'b0; on = 1'b0; rd_t = 0; idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || layer == 3'b000) begin
                on = 1'b0;
            end else if (integration_start) begin
                on   = 1'b1;
                rd_t = 0;
                idx  = layer[0] ? 0 : (layer[1] ? 1 : 2);
            end else if (on) begin
                rd_t++;
            end
            abs_valid  = on && rd_t >= 3 && rd_t < 3 + rd_abs[idx];
            sign_valid = on && rd_t >= 3 && rd_t < 3 + rd_sign[idx];
        end
    end

    // Output monitor and scoreboard consumer.
    initial begin
        logic [2:0] prev_layer;
        logic       prev_serr;
        exp_t       e;
        prev_layer = 3'b000; prev_serr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (layer !== prev_layer) begin
                    seq.push_back(layer);
                    prev_layer = layer;
                end
                if (integration_start) begin
                    n_istart++;
                    istart_cyc = cyc;
                    if (layer == 3'b000) viol++;
                end
                if (!(layer inside {3'b000, 3'b001, 3'b010, 3'b100})) viol++;
                if (layer == 3'b000 && !idle) begin
                    zrun++;
                end else if (zrun != 0) begin
                    last_gap = zrun;
                    zrun = 0;
                end
                if (layer_done) begin
                    n_ldone++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_layer_done actual=1 expected=0");
                    end else begin
                        e = sb.pop_front();
                        check("ld_beat_err", beat_err, e.b);
                        check("ld_sync_err", sync_err, e.s);
                        check("ld_start_err", start_err, e.st);
                        check("ld_layer_zero", layer, 0);
                    end
                end
                if (inf_done) n_idone++;
                if (start_err && !prev_serr) start_lat = cyc - istart_cyc;
                prev_serr = start_err;
            end else begin
                prev_layer = 3'b000;
                zrun = 0;
            end
        end
    end

    task automatic start_inf(input int a1, input int a2, input int a3,
                             input int s1, input int s2, input int s3);
        exp_t e;
        int   ca;
        rd_abs  = '{a1, a2, a3};
        rd_sign = '{s1, s2, s3};
        e.b = 1'b0; e.s = 1'b0; e.st = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rd_abs[i] == 0 && rd_sign[i] == 0) begin
                e.st = 1'b1;
            end else begin
                ca = (rd_abs[i] > 7) ? 7 : rd_abs[i];
                if (ca != exp_n[i]) e.b = 1'b1;
                if (rd_abs[i] != rd_sign[i]) e.s = 1'b1;
            end
            sb.push_back(e);
        end
        seq.delete();
        n_istart = 0; n_ldone = 0; n_idone = 0; start_lat = -1;
        @(negedge clk);
        inf_start = 1'b1;
        @(negedge clk);
        inf_start = 1'b0;
        check("armed_layer", layer, 3'b001);
        check("armed_idle", idle, 0);
        check("clr_errs", {beat_err, sync_err, start_err}, 0);
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (inf_done) got = 1'b1;
        end
        check("inf_done_seen", got, 1);
        if (got) begin
            @(negedge clk);
            check("inf_done_single", inf_done, 0);
        end
    endtask

    task automatic wait_layer(input logic [2:0] l);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (layer == l) got = 1'b1;
        end
        check("layer_reached", got, 1);
    endtask

    task automatic end_checks(input logic eb, input logic es, input logic est);
        check("layer_seq_len", seq.size(), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++) check("layer_seq", seq[i], exp_seq[i]);
        check("n_istart", n_istart, 3);
        check("n_layer_done", n_ldone, 3);
        check("n_inf_done", n_idone, 1);
        check("final_beat_err", beat_err, eb);
        check("final_sync_err", sync_err, es);
        check("final_start_err", start_err, est);
        check("timeout_err", timeout_err, 0);
        check("idle_after", idle, 1);
        check("sb_empty", sb.size(), 0);
        check("gap_cycles", last_gap, 4);
    endtask

    initial begin
        logic got;
        int   hold_bad;
        vecs[0] = '{4, 3, 2, 4, 3, 2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{5, 3, 2, 5, 3, 2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4, 3, 2, 3, 3, 2, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{0, 3, 2, 0, 3, 2, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{12, 3, 2, 12, 3, 2, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4, 3, 1, 4, 3, 1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4, 0, 2, 4, 3, 2, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{4, 3, 2, 4, 3, 2, 1'b0, 1'b0, 1'b0};
        n_istart = 0; n_ldone = 0; n_idone = 0; viol = 0; start_lat = -1;
        istart_cyc = 0; zrun = 0; last_gap = 0;
        rd_abs = '{0, 0, 0}; rd_sign = '{0, 0, 0};
        rst_n = 1'b0; inf_start = 1'b0; act_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_layer", layer, 0);
        check("rst_idle", idle, 1);
        check("rst_pulses", {integration_start, layer_done, inf_done}, 0);
        check("rst_errs", {beat_err, sync_err, start_err, timeout_err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", idle, 1);
        check("post_rst_layer", layer, 0);

        for (int r = 0; r < 8; r++) begin
            start_inf(vecs[r].a1, vecs[r].a2, vecs[r].a3, vecs[r].s1, vecs[r].s2, vecs[r].s3);
            wait_done();
            end_checks(vecs[r].eb, vecs[r].es, vecs[r].est);
            if (vecs[r].est) check("start_err_latency", start_lat, 9);
        end

        // act_ready held low in ARM of layer 2
        start_inf(4, 3, 2, 4, 3, 2);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (layer_done) got = 1'b1;
        end
        check("l1_done_seen", got, 1);
        act_ready = 1'b0;
        wait_layer(3'b010);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (integration_start || layer != 3'b010) hold_bad++;
            @(negedge clk);
        end
        check("hold_no_start", hold_bad, 0);
        check("hold_istart_count", n_istart, 1);
        act_ready = 1'b1;
        @(negedge clk);
        check("start_after_ready", integration_start, 1);
        check("start_layer", layer, 3'b010);
        wait_done();
        end_checks(1'b0, 1'b0, 1'b0);

        // inf_start while busy is ignored
        start_inf(4, 3, 2, 4, 3, 2);
        wait_layer(3'b010);
        inf_start = 1'b1;
        @(negedge clk);
        inf_start = 1'b0;
        wait_done();
        end_checks(1'b0, 1'b0, 1'b0);

        // reset in the middle of layer 2 streaming
        start_inf(4, 3, 2, 4, 3, 2);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (layer == 3'b010 && abs_valid) got = 1'b1;
        end
        check("l2_stream_seen", got, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_layer", layer, 0);
        check("abort_idle", idle, 1);
        check("abort_pulses", {integration_start, layer_done, inf_done}, 0);
        check("abort_ldone_count", n_ldone, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_inf_done", n_idone, 0);
        check("abort_still_idle", idle, 1);
        check("abort_sb_left", sb.size(), 2);
        sb.delete();

        start_inf(4, 3, 2, 4, 3, 2);
        wait_done();
        end_checks(1'b0, 1'b0, 1'b0);

        check("onehot_and_start_layer", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
